pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
//  Consumer end of the branch interface. Owns the architectural PC and the link register (LR).
//  Accepts branch targets and link values from the branch datapath, and return requests (BX LR).
//  Drives the fetch address with a valid/ready handshake and flushes the pipeline on every redirect.
//  Sits between the execute-stage branch logic and the instruction fetch port.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded on reset
//  PC_STEP       2              sequential increment (Thumb halfword)
//  FLUSH_CYCLES  2              cycles flush held high after a redirect; legal range 1..15
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  br_valid     in   1   branch resolved this cycle
//  br_target    in   32  branch target address (in_PC + offset)
//  br_link      in   1   branch is BL; capture br_lr
//  br_lr        in   32  return address supplied with BL
//  ret_valid    in   1   return request (BX LR)
//  fetch_ready  in   1   fetch port accepts fetch_addr
//  fetch_valid  out  1   fetch_addr valid
//  fetch_addr   out  32  current PC, bit0 always 0
//  flush        out  1   squash younger pipeline stages
//  lr_out       out  32  current LR
//  ret_fault    out  1   sticky: return attempted with LR[0]==0
// BEHAVIOUR
//  Reset (async, any state):
//   pc=RESET_PC, lr=32'hFFFF_FFFF, state=IDLE, fetch_valid=0, flush=0, ret_fault=0, counter=0.
//  FSM states and transitions:
//   IDLE:  one cycle after reset release, then RUN. fetch_valid=0.
//   RUN:   fetch_valid=1.
//          Redirect -> FLUSH, counter=FLUSH_CYCLES-1.
//          Otherwise, on fetch_valid&&fetch_ready: pc <= pc+PC_STEP.
//   FLUSH: fetch_valid=0, flush=1. Counter decrements; at 0 -> RUN.
//          A redirect in FLUSH reloads pc and restarts the counter at FLUSH_CYCLES-1.
//  Redirect sources:
//   br_valid=1:                          pc <= {br_target[31:1],1'b0}.
//   ret_valid=1, br_valid=0, lr[0]=1:    pc <= {lr[31:1],1'b0}.
//   ret_valid=1, br_valid=0, lr[0]=0:    no redirect; ret_fault <= 1 (sticky); pc continues.
//   br_valid and ret_valid together:     br_valid wins; ret_valid is ignored.
//  LR:
//   br_valid&&br_link: lr <= br_lr | 32'h1 on the same edge as the pc load.
//   br_link is ignored when br_valid=0.
//   BL with ret_valid in the same cycle: return ignored, lr updated.
//  Latency:
//   Redirect sampled at edge N -> fetch_addr=target from edge N.
//   fetch_valid rises at edge N+FLUSH_CYCLES.
//   flush is high for exactly FLUSH_CYCLES cycles.
//  Handshake:
//   While fetch_valid&&!fetch_ready, fetch_addr is held stable.
//   Redirect in the same cycle as fetch_ready: the transfer completes but is squashed by flush;
//   pc takes the target, not pc+PC_STEP.
//  Width/wrap: pc arithmetic is modulo 2^32; 32'hFFFF_FFFE + 2 -> 32'h0000_0000.
//  Redirect in IDLE: accepted and applied as in RUN (-> FLUSH).
// STRUCTURE
//  Shared package cm0_pc_pkg holds:
//   state encoding (IDLE/RUN/FLUSH), LR_RESET=32'hFFFF_FFFF, THUMB_BIT=0.
//  Sub-module pc_flush_timer: loadable down-counter, 4 bits, outputs busy/done.
//  Everything else stays in this module.
//  Parameter check: simulation-time error if FLUSH_CYCLES==0 or FLUSH_CYCLES>15.
// TESTING
//  1 Reset then fetch_ready=1 for 4 cycles
//    -> fetch_addr 0,2,4,6; lr=FFFF_FFFF; flush=0.
//  2 br_valid, br_target=0x0000_0101, br_link=1, br_lr=0x0000_0008 at pc=6
//    -> fetch_addr=0x100; lr=0x0000_0009; flush high 2 cycles; fetch_valid low 2 cycles;
//       then 0x100, 0x102.
//  3 ret_valid at pc=0x104 with lr=0x9
//    -> fetch_addr=0x8 after flush; ret_valid with lr=0x8 -> ret_fault=1, no redirect.
//  4 br_valid and ret_valid same cycle (target 0x200, lr=0x41)
//    -> pc=0x200; second br_valid during FLUSH (0x300) -> pc=0x300, flush extended.
//  5 fetch_ready=0 for 3 cycles at pc=0x10 -> fetch_addr holds 0x10;
//    pc=32'hFFFF_FFFE accepted -> next 0x0.
//  6 Assert rst in mid-FLUSH -> all outputs to reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/cm0_pc_pkg.sv
// Shared definitions for the PC/LR redirect controller: FSM encoding and
// architectural reset constants.
package cm0_pc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } pc_state_e;

    localparam logic [31:0] LR_RESET  = 32'hFFFF_FFFF;
    localparam int          THUMB_BIT = 0;

endpackage

// File: rtl/pc_flush_timer.sv
// Loadable 4-bit down-counter that times how long the pipeline flush stays
// asserted after a redirect.
module pc_flush_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       busy,
    output logic       done
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 4'd0;
        else     cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != 4'd0);
    assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Owns the architectural PC and LR, applies branch/return redirects and drives
// the fetch port with a valid/ready handshake plus a timed pipeline flush.
module pc_redirect_ctrl
    import cm0_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          PC_STEP      = 2,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        br_link,
    input  logic [31:0] br_lr,
    input  logic        ret_valid,
    input  logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_addr,
    output logic        flush,
    output logic [31:0] lr_out,
    output logic        ret_fault
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
        $error("pc_redirect_ctrl: FLUSH_CYCLES must be in 1..15");
    end

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] lr_q, lr_d;
    logic        fault_q, fault_d;
    logic        ret_ok, ret_bad, redirect;
    logic        tmr_busy, tmr_done;

    // A branch always beats a return; a return only redirects on a Thumb LR.
    assign ret_ok   = ret_valid && !br_valid &&  lr_q[THUMB_BIT];
    assign ret_bad  = ret_valid && !br_valid && !lr_q[THUMB_BIT];
    assign redirect = br_valid || ret_ok;

    pc_flush_timer u_flush_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (redirect),
        .load_val (4'(FLUSH_CYCLES - 1)),
        .busy     (tmr_busy),
        .done     (tmr_done)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lr_d    = lr_q;
        fault_d = fault_q || ret_bad;

        if (br_valid && br_link)
            lr_d = br_lr | 32'h1;

        if (br_valid)
            pc_d = {br_target[31:1], 1'b0};
        else if (ret_ok)
            pc_d = {lr_q[31:1], 1'b0};
        else if (state_q == ST_RUN && fetch_ready)
            pc_d = pc_q + 32'(PC_STEP);

        case (state_q)
            ST_IDLE:  state_d = redirect ? ST_FLUSH : ST_RUN;
            ST_RUN:   state_d = redirect ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_d = (redirect || !tmr_done) ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            lr_q    <= LR_RESET;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            lr_q    <= lr_d;
            fault_q <= fault_d;
        end
    end

    // The timer only runs while flushing.
    always_comb begin
        if (tmr_busy) assert (state_q == ST_FLUSH);
    end

    assign fetch_valid = (state_q == ST_RUN);
    assign flush       = (state_q == ST_FLUSH);
    assign fetch_addr  = {pc_q[31:1], 1'b0};
    assign lr_out      = lr_q;
    assign ret_fault   = fault_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: a cycle model pushes expected outputs
// as stimulus is driven; they are popped and compared after the clock edge.
module tb_pc_redirect_ctrl;

    localparam int F = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid, br_link, ret_valid, fetch_ready;
    logic [31:0] br_target, br_lr;
    logic        fetch_valid, flush, ret_fault;
    logic [31:0] fetch_addr, lr_out;

    pc_redirect_ctrl #(.RESET_PC(32'h0), .PC_STEP(2), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_target(br_target),
        .br_link(br_link), .br_lr(br_lr), .ret_valid(ret_valid),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
        .fetch_addr(fetch_addr), .flush(flush), .lr_out(lr_out),
        .ret_fault(ret_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fv;
        logic        fl;
        logic [31:0] addr;
        logic [31:0] lr;
        logic        fault;
    } exp_t;

    exp_t q_exp[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    logic [31:0] m_pc, m_lr;
    logic        m_fault, m_idle;
    int          m_rem;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.fv    = !m_idle && (m_rem == 0);
        e.fl    = (m_rem > 0);
        e.addr  = m_pc;
        e.lr    = m_lr;
        e.fault = m_fault;
        return e;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_lr = 32'hFFFF_FFFF; m_fault = 1'b0; m_idle = 1'b1; m_rem = 0;
    endtask

    task automatic cmp_out(input string tag, input exp_t e);
        chk({tag, ".fv"},    32'(fetch_valid), 32'(e.fv));
        chk({tag, ".flush"}, 32'(flush),       32'(e.fl));
        chk({tag, ".addr"},  fetch_addr,       e.addr);
        chk({tag, ".lr"},    lr_out,           e.lr);
        chk({tag, ".fault"}, 32'(ret_fault),   32'(e.fault));
    endtask

    // Drive one cycle of stimulus (called at negedge), advance the model,
    // then check the DUT at the following negedge.
    task automatic step(input string tag, input logic br, input logic [31:0] tgt,
                        input logic lnk, input logic [31:0] blr, input logic ret,
                        input logic rdy);
        logic fv_now;
        exp_t e;
        br_valid = br; br_target = tgt; br_link = lnk; br_lr = blr;
        ret_valid = ret; fetch_ready = rdy;
        fv_now = !m_idle && (m_rem == 0);
        if (ret && !br && !m_lr[0]) m_fault = 1'b1;
        if (br) begin
            m_pc = tgt & 32'hFFFF_FFFE; m_rem = F;
        end else if (ret && m_lr[0]) begin
            m_pc = m_lr & 32'hFFFF_FFFE; m_rem = F;
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (fv_now && rdy) begin
            m_pc = m_pc + 32'd2;
        end
        if (br && lnk) m_lr = blr | 32'h1;
        m_idle = 1'b0;
        q_exp.push_back(model_out());
        @(posedge clk);
        @(negedge clk);
        if (q_exp.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = q_exp.pop_front();
            cmp_out(tag, e);
        end
    endtask

    task automatic idle_step(input string tag, input logic rdy);
        step(tag, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
    endtask

    task automatic br_step(input string tag, input logic [31:0] tgt, input logic lnk,
                           input logic [31:0] blr, input logic ret);
        step(tag, 1'b1, tgt, lnk, blr, ret, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        br_valid = 0; br_target = 0; br_link = 0; br_lr = 0; ret_valid = 0; fetch_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        cmp_out("reset", model_out());
        rst = 1'b0;

        // 1: sequential fetch 0,2,4,6
        idle_step("t1.idle", 1'b1);
        chk("t1.addr0", fetch_addr, 32'h0);
        repeat (3) idle_step("t1.seq", 1'b1);
        chk("t1.addr6", fetch_addr, 32'h6);

        // 2: BL at pc=6 with fetch_ready high in the same cycle
        br_step("t2.bl", 32'h0000_0101, 1'b1, 32'h0000_0008, 1'b0);
        chk("t2.addr", fetch_addr, 32'h100);
        chk("t2.lr", lr_out, 32'h9);
        chk("t2.flush1", 32'(flush), 32'd1);
        idle_step("t2.fl2", 1'b1);
        chk("t2.flush2", 32'(flush), 32'd1);
        idle_step("t2.run", 1'b1);
        chk("t2.fv_back", 32'(fetch_valid), 32'd1);
        repeat (2) idle_step("t2.seq", 1'b1);
        chk("t2.addr104", fetch_addr, 32'h104);

        // 3: return through LR=0x9
        step("t3.ret", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (F) idle_step("t3.fl", 1'b1);
        chk("t3.addr8", fetch_addr, 32'h8);
        chk("t3.nofault", 32'(ret_fault), 32'd0);

        // 4: branch beats return; second branch inside flush restarts it
        br_step("t4.br_ret", 32'h200, 1'b1, 32'h40, 1'b1);
        chk("t4.addr", fetch_addr, 32'h200);
        chk("t4.lr", lr_out, 32'h41);
        br_step("t4.br2", 32'h300, 1'b0, 32'h0, 1'b0);
        chk("t4.addr2", fetch_addr, 32'h300);
        idle_step("t4.fl", 1'b1);
        chk("t4.ext", 32'(flush), 32'd1);
        repeat (2) idle_step("t4.run", 1'b1);

        // 5: stall holds address; wrap at top of address space
        br_step("t5.br", 32'h10, 1'b0, 32'h0, 1'b0);
        repeat (F) idle_step("t5.fl", 1'b0);
        repeat (3) idle_step("t5.stall", 1'b0);
        chk("t5.hold", fetch_addr, 32'h10);
        br_step("t5.top", 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
        repeat (F) idle_step("t5.fl2", 1'b1);
        chk("t5.fffe", fetch_addr, 32'hFFFF_FFFE);
        idle_step("t5.wrap", 1'b1);
        chk("t5.wrap0", fetch_addr, 32'h0);

        // 6: asynchronous reset in the middle of a flush
        br_step("t6.br", 32'h50, 1'b1, 32'h70, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        cmp_out("t6.async", model_out());
        @(negedge clk);
        rst = 1'b0;

        // redirect straight out of IDLE
        br_step("t7.idle_br", 32'h80, 1'b0, 32'h0, 1'b0);
        chk("t7.addr", fetch_addr, 32'h80);
        repeat (F) idle_step("t7.fl", 1'b1);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            logic br, ret, lnk, rdy;
            br  = ($urandom_range(0, 7) == 0);
            ret = ($urandom_range(0, 7) == 0);
            lnk = $urandom_range(0, 1) == 1;
            rdy = $urandom_range(0, 3) != 0;
            step("rnd", br, $urandom, lnk, $urandom, ret, rdy);
        end

        chk("sb.drained", 32'(q_exp.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
